stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for the stopwatch datapath. Takes the four BCD digits captured by the user-input block (A,B,C,D = MM:SS) as a preset and runs the timer as an up-counter or count-down from that preset. It handles start/stop/clear from two push-button levels and drives the four display digits. It sits between the user-input registers and the 7-segment display driver.

## Interface
- TICK_DIV, 50000000, clk cycles per one-second tick (≥2; benches use 4)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start_btn  in  1  start/resume button level, synchronous to clk
- stop_btn  in  1  pause/clear button level, synchronous to clk
- mode  in  1  0 = count up, 1 = count down; sampled on entry to RUN from IDLE
- load  in  1  one-cycle pulse: capture A,B,C,D as preset
- A  in  4  preset tens of minutes (BCD)
- B  in  4  preset minutes (BCD)
- C  in  4  preset tens of seconds (BCD)
- D  in  4  preset seconds (BCD)
- M1,M0,S1,S0  out  4 each  displayed digits MM:SS
- running  out  1  high in RUN
- done  out  1  high in DONE
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Button edges: registered previous sample per button; start_ev = start_btn & ~start_q, same for stop_ev. Levels held high produce one event only.
- Preset capture on load in IDLE only, with clamping: A>5→5, B>9→9, C>5→5, D>9→9. Captured digits go straight to M1,M0,S1,S0. load ignored in RUN/PAUSE/DONE.
- IDLE: start_ev → RUN. Latch mode internally and clear the prescaler. In down mode with digits 00:00 → DONE instead.
- RUN: the prescaler counts 0..TICK_DIV-1. tick is asserted at TICK_DIV-1, after which the prescaler wraps to 0.
  - Up mode: on tick, increment in BCD. S0 9→0 carries into S1; S1 5→0 carries into M0; M0 9→0 carries into M1.
  - Down mode: on tick, decrement with the mirrored borrows.
  - Up reaching 59:59, or down reaching 00:00, → DONE on the same edge as that digit update.
  - stop_ev → PAUSE.
- PAUSE: digits and prescaler are frozen. start_ev → RUN, resuming with the same prescaler value and the latched mode. stop_ev → IDLE with digits cleared to 00:00.
- DONE: digits hold the final value. stop_ev → IDLE, digits 00:00. start_ev ignored.
- Same-cycle start_ev and stop_ev: stop wins in every state.
- Same-cycle tick and stop_ev in RUN: the digit update is applied, then the state goes to PAUSE. If the update hits the terminal count, DONE takes precedence over PAUSE.

## Timing
- Reset asserted (reset=0), async: state=IDLE, digits=0, prescaler=0, running=0, done=0, button history=0, latched mode=0.
- Reset mid-run takes effect immediately. After release, the block is in IDLE and the first button level high counts as an edge.
- Event latency: button rises in cycle n → state changes at the edge ending cycle n. running/done/state are registered and valid from cycle n+1.
- Load latency: load in cycle n → digits show the clamped preset from cycle n+1.
- First tick after start_ev in cycle n: digits change at the edge ending cycle n+TICK_DIV.
- All outputs are registered; no combinational input→output paths.

## Test plan
- Up count, TICK_DIV=4: load 00:58, mode=0, start pulse → 00:59 after 4 cycles, 01:00 after 8 with carry. Separately, load 59:58 → 59:59 and DONE with done=1 after 4 cycles.
- Down count: load 01:00, mode=1, start → 00:59 after 4 cycles (borrow chain). Load 00:01 → 00:00 and DONE after 4 cycles. Start at 00:00 → DONE next cycle, digits unchanged.
- Pause/resume: start, stop after 6 cycles (prescaler=2) → PAUSE, digits frozen for 20 cycles. Start → next tick after 2 cycles. Second stop in PAUSE → IDLE, 00:00.
- Clamp and load gating: load A=9,B=12,C=7,D=15 → 59:59. load during RUN leaves digits unchanged.
- Simultaneous events: start_btn and stop_btn rise together in IDLE → stays IDLE. The same in RUN → PAUSE. Holding start_btn high → exactly one transition.
- Async reset at mid-RUN, not aligned to clk → all outputs 0 and state=IDLE immediately. Normal operation after reset=1.

Source files
------------

// File: rtl/stopwatch_if.sv
// User-side signal bundle of the stopwatch controller: buttons, preset digits in,
// displayed digits and status out.
interface stopwatch_if;
    logic       start_btn;
    logic       stop_btn;
    logic       mode;
    logic       load;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] C;
    logic [3:0] D;
    logic [3:0] M1;
    logic [3:0] M0;
    logic [3:0] S1;
    logic [3:0] S0;
    logic       running;
    logic       done;
    logic [1:0] state;

    modport master (
        output start_btn, stop_btn, mode, load, A, B, C, D,
        input  M1, M0, S1, S0, running, done, state
    );

    modport slave (
        input  start_btn, stop_btn, mode, load, A, B, C, D,
        output M1, M0, S1, S0, running, done, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: MM:SS BCD up/down timer with preset load, start/pause/clear
// from button edges, and a TICK_DIV-cycle one-second prescaler.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    stopwatch_if.slave sw
);
    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        st;
    logic          start_q, stop_q, mode_q;
    logic [PW-1:0] pre;
    logic [3:0]    m1, m0, s1, s0;
    logic          running_q, done_q;

    logic          start_ev, stop_ev, tick, terminal;
    logic [3:0]    n_m1, n_m0, n_s1, n_s0;

    assign start_ev = sw.start_btn & ~start_q;
    assign stop_ev  = sw.stop_btn  & ~stop_q;
    assign tick     = (pre == PRE_MAX);

    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Next display value one second later in the latched direction, with the
    // carry/borrow ripple and terminal-count detection.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        n_m1     = m1;
        n_m0     = m0;
        n_s1     = s1;
        n_s0     = s0;
        terminal = 1'b0;
        if (!mode_q) begin
            if (s0 != 4'd9) n_s0 = s0 + 4'd1;
            else begin
                n_s0 = 4'd0;
                if (s1 != 4'd5) n_s1 = s1 + 4'd1;
                else begin
                    n_s1 = 4'd0;
                    if (m0 != 4'd9) n_m0 = m0 + 4'd1;
                    else begin
                        n_m0 = 4'd0;
                        n_m1 = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
                    end
                end
            end
            terminal = (n_m1 == 4'd5) && (n_m0 == 4'd9) && (n_s1 == 4'd5) && (n_s0 == 4'd9);
        end else begin
            if (s0 != 4'd0) n_s0 = s0 - 4'd1;
            else begin
                n_s0 = 4'd9;
                if (s1 != 4'd0) n_s1 = s1 - 4'd1;
                else begin
                    n_s1 = 4'd5;
                    if (m0 != 4'd0) n_m0 = m0 - 4'd1;
                    else begin
                        n_m0 = 4'd9;
                        n_m1 = (m1 == 4'd0) ? 4'd5 : m1 - 4'd1;
                    end
                end
            end
            terminal = (n_m1 == 4'd0) && (n_m0 == 4'd0) && (n_s1 == 4'd0) && (n_s0 == 4'd0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            mode_q    <= 1'b0;
            pre       <= '0;
            m1        <= 4'd0;
            m0        <= 4'd0;
            s1        <= 4'd0;
            s0        <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees pre-edge values.
            start_q <= sw.start_btn;
            stop_q  <= sw.stop_btn;
            case (st)
                IDLE: begin
                    if (sw.load) begin
                        m1 <= clamp(sw.A, 4'd5);
                        m0 <= clamp(sw.B, 4'd9);
                        s1 <= clamp(sw.C, 4'd5);
                        s0 <= clamp(sw.D, 4'd9);
                    end
                    if (start_ev && !stop_ev) begin
                        mode_q <= sw.mode;
                        pre    <= '0;
                        if (sw.mode && {m1, m0, s1, s0} == 16'h0000) begin
                            st     <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            st        <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    pre <= tick ? '0 : pre + 1'b1;
                    if (tick) begin
                        m1 <= n_m1;
                        m0 <= n_m0;
                        s1 <= n_s1;
                        s0 <= n_s0;
                    end
                    // Terminal count beats a coincident pause request.
                    if (tick && terminal) begin
                        st        <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (stop_ev) begin
                        st        <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (stop_ev) begin
                        st  <= IDLE;
                        pre <= '0;
                        m1  <= 4'd0;
                        m0  <= 4'd0;
                        s1  <= 4'd0;
                        s0  <= 4'd0;
                    end else if (start_ev) begin
                        st        <= RUN;
                        running_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (stop_ev) begin
                        st     <= IDLE;
                        done_q <= 1'b0;
                        m1     <= 4'd0;
                        m0     <= 4'd0;
                        s1     <= 4'd0;
                        s0     <= 4'd0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign sw.M1      = m1;
    assign sw.M0      = m0;
    assign sw.S1      = s1;
    assign sw.S0      = s0;
    assign sw.running = running_q;
    assign sw.done    = done_q;
    assign sw.state   = st;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a seconds-count reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_stopwatch_ctrl;
    localparam int TD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   compare_en = 1'b0;

    stopwatch_if sw();

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed time as a plain seconds count (0..3599).
    int m_state = 0;
    int secs    = 0;
    int pre     = 0;
    bit m_mode  = 1'b0;
    bit sq      = 1'b0;
    bit pq      = 1'b0;

    function automatic int to_secs(input int a, input int b, input int c, input int d);
        return ((a > 5) ? 5 : a) * 600 + ((b > 9) ? 9 : b) * 60 + ((c > 5) ? 5 : c) * 10 + ((d > 9) ? 9 : d);
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit sev, pev, tk;
        if (!reset) begin
            m_state = 0; secs = 0; pre = 0; m_mode = 1'b0; sq = 1'b0; pq = 1'b0;
        end else begin
            sev = sw.start_btn && !sq;
            pev = sw.stop_btn && !pq;
            sq  = sw.start_btn;
            pq  = sw.stop_btn;
            case (m_state)
                0: begin
                    if (sev && !pev) begin
                        m_mode  = sw.mode;
                        pre     = 0;
                        m_state = (sw.mode && secs == 0) ? 3 : 1;
                    end
                    if (sw.load) secs = to_secs(int'(sw.A), int'(sw.B), int'(sw.C), int'(sw.D));
                end
                1: begin
                    tk  = (pre == TD - 1);
                    pre = tk ? 0 : pre + 1;
                    if (tk) begin
                        secs = m_mode ? secs - 1 : (secs + 1) % 3600;
                        if ((!m_mode && secs == 3599) || (m_mode && secs == 0)) m_state = 3;
                        else if (pev) m_state = 2;
                    end else if (pev) m_state = 2;
                end
                2: begin
                    if (pev) begin m_state = 0; secs = 0; pre = 0; end
                    else if (sev) m_state = 1;
                end
                default: if (pev) begin m_state = 0; secs = 0; end
            endcase
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (compare_en) begin
            check("cyc_M1",      sw.M1,      secs / 600);
            check("cyc_M0",      sw.M0,      (secs / 60) % 10);
            check("cyc_S1",      sw.S1,      (secs % 60) / 10);
            check("cyc_S0",      sw.S0,      secs % 10);
            check("cyc_state",   sw.state,   m_state);
            check("cyc_running", sw.running, (m_state == 1) ? 1 : 0);
            check("cyc_done",    sw.done,    (m_state == 3) ? 1 : 0);
        end
    end

    task automatic check_disp(input string nm, input int m1, input int m0, input int s1, input int s0);
        check({nm, "_M1"}, sw.M1, m1);
        check({nm, "_M0"}, sw.M0, m0);
        check({nm, "_S1"}, sw.S1, s1);
        check({nm, "_S0"}, sw.S0, s0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        @(negedge clk) sw.start_btn = 1'b1;
        @(negedge clk) sw.start_btn = 1'b0;
    endtask

    task automatic press_stop();
        @(negedge clk) sw.stop_btn = 1'b1;
        @(negedge clk) sw.stop_btn = 1'b0;
    endtask

    task automatic press_both();
        @(negedge clk) begin sw.start_btn = 1'b1; sw.stop_btn = 1'b1; end
        @(negedge clk) begin sw.start_btn = 1'b0; sw.stop_btn = 1'b0; end
    endtask

    task automatic do_load(input int a, input int b, input int c, input int d);
        @(negedge clk) begin
            sw.load = 1'b1;
            sw.A = 4'(a); sw.B = 4'(b); sw.C = 4'(c); sw.D = 4'(d);
        end
        @(negedge clk) sw.load = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sw.start_btn = 1'b0; sw.stop_btn = 1'b0; sw.mode = 1'b0; sw.load = 1'b0;
        sw.A = 4'd0; sw.B = 4'd0; sw.C = 4'd0; sw.D = 4'd0;
        @(posedge clk);
        compare_en = 1'b1;
        wait_cyc(2);
        check("rst_state", sw.state, 0);
        check_disp("rst", 0, 0, 0, 0);
        reset = 1'b1;

        // Up count with seconds-to-minutes carry.
        do_load(0, 0, 5, 8);
        check_disp("load_0058", 0, 0, 5, 8);
        sw.mode = 1'b0;
        press_start();
        check("up_running", sw.running, 1);
        wait_cyc(4);
        check_disp("up_0059", 0, 0, 5, 9);
        wait_cyc(4);
        check_disp("up_0100", 0, 1, 0, 0);
        press_stop();
        check("up_pause", sw.state, 2);
        press_stop();
        check("up_clear_state", sw.state, 0);
        check_disp("up_clear", 0, 0, 0, 0);

        // Up to terminal 59:59.
        do_load(5, 9, 5, 8);
        press_start();
        wait_cyc(4);
        check_disp("up_term", 5, 9, 5, 9);
        check("up_term_done", sw.done, 1);
        check("up_term_state", sw.state, 3);
        press_start();
        check("done_ign_start", sw.state, 3);
        press_stop();
        check("done_clear", sw.state, 0);

        // Down count with full borrow chain.
        sw.mode = 1'b1;
        do_load(0, 1, 0, 0);
        press_start();
        wait_cyc(4);
        check_disp("dn_0059", 0, 0, 5, 9);
        check("dn_run", sw.state, 1);
        press_stop();
        press_stop();

        // Down to 00:00.
        do_load(0, 0, 0, 1);
        press_start();
        wait_cyc(4);
        check_disp("dn_zero", 0, 0, 0, 0);
        check("dn_zero_state", sw.state, 3);
        press_stop();

        // Down start at 00:00 goes straight to DONE.
        press_start();
        check("dn_imm_done", sw.state, 3);
        check_disp("dn_imm", 0, 0, 0, 0);
        press_stop();

        // Pause holds prescaler phase; resume ticks 2 cycles later.
        sw.mode = 1'b0;
        do_load(0, 0, 1, 0);
        press_start();
        wait_cyc(4);
        press_stop();
        check("pause_state", sw.state, 2);
        check_disp("pause_0011", 0, 0, 1, 1);
        wait_cyc(20);
        check_disp("pause_frozen", 0, 0, 1, 1);
        press_start();
        wait_cyc(1);
        check_disp("resume_pre", 0, 0, 1, 1);
        wait_cyc(1);
        check_disp("resume_tick", 0, 0, 1, 2);
        press_stop();
        press_stop();
        check("pause_clear", sw.state, 0);
        check_disp("pause_clear", 0, 0, 0, 0);

        // Clamp, and load ignored while running.
        do_load(9, 12, 7, 15);
        check_disp("clamp", 5, 9, 5, 9);
        do_load(0, 0, 0, 0);
        press_start();
        do_load(3, 3, 3, 3);
        check_disp("load_gated", 0, 0, 0, 0);
        check("load_gated_state", sw.state, 1);
        press_stop();
        press_stop();

        // Simultaneous start/stop: stop wins.
        press_both();
        check("both_idle", sw.state, 0);
        press_start();
        press_both();
        check("both_run", sw.state, 2);
        press_stop();

        // Held start gives exactly one event.
        @(negedge clk) sw.start_btn = 1'b1;
        wait_cyc(6);
        check("hold_run", sw.state, 1);
        press_stop();
        wait_cyc(3);
        check("hold_pause", sw.state, 2);
        @(negedge clk) sw.start_btn = 1'b0;
        press_stop();
        check("hold_idle", sw.state, 0);

        // Asynchronous reset mid-run.
        do_load(0, 0, 5, 8);
        press_start();
        wait_cyc(5);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_state", sw.state, 0);
        check("arst_running", sw.running, 0);
        check("arst_done", sw.done, 0);
        check_disp("arst", 0, 0, 0, 0);
        sw.start_btn = 1'b1;
        wait_cyc(2);
        reset = 1'b1;
        @(negedge clk) sw.start_btn = 1'b0;
        check("post_rst_run", sw.state, 1);
        wait_cyc(4);
        check_disp("post_rst_0001", 0, 0, 0, 1);

        wait_cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
